// File: rtl/des_pkg.sv
// ----------------------------------------------------------------------------
// des_pkg
// Shared definitions for the DES key schedule controller.
//   - Width constants KEY_W, CD_W, HALF_W, SK_W
//   - Controller state encoding (state_t: ST_IDLE, ST_ROUND, ST_DONE)
//   - PC-1 selection table (56 entries) and per-round SHIFT table (16 entries)
//   - Helpers: pc1(), rotate_left(), rotate_right(), key_parity_ok()
// All bit numbering follows the DES standard: 1-based, MSB first, so DES
// bit n of a W-bit vector lives at vector index W-n.
// ----------------------------------------------------------------------------
package des_pkg;

    localparam int KEY_W  = 64;
    localparam int CD_W   = 56;
    localparam int HALF_W = 28;
    localparam int SK_W   = 48;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ROUND = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    localparam int PC1_TABLE [0:55] = '{
        57, 49, 41, 33, 25, 17,  9,
         1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27,
        19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,
         7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29,
        21, 13,  5, 28, 20, 12,  4
    };

    localparam int SHIFT_TABLE [0:15] = '{
        1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1
    };

    // PC-1: drop the eight parity bits and permute the rest into C||D.
    function automatic logic [CD_W-1:0] pc1(input logic [KEY_W-1:0] key);
        logic [CD_W-1:0] cd;
        cd = '0;
        for (int i = 0; i < CD_W; i++) begin
            cd[6'(CD_W - 1 - i)] = key[6'(KEY_W - PC1_TABLE[i])];
        end
        return cd;
    endfunction

    // DES only ever rotates by 1 or 2 places.
    function automatic logic [HALF_W-1:0] rotate_left(input logic [HALF_W-1:0] half,
                                                      input int amount);
        if (amount == 2) begin
            return {half[HALF_W-3:0], half[HALF_W-1:HALF_W-2]};
        end
        return {half[HALF_W-2:0], half[HALF_W-1]};
    endfunction

    function automatic logic [HALF_W-1:0] rotate_right(input logic [HALF_W-1:0] half,
                                                       input int amount);
        if (amount == 2) begin
            return {half[1:0], half[HALF_W-1:2]};
        end
        return {half[0], half[HALF_W-1:1]};
    endfunction

    // True when every key byte carries odd parity.
    function automatic logic key_parity_ok(input logic [KEY_W-1:0] key);
        logic             ok;
        logic [KEY_W-1:0] shifted;
        ok = 1'b1;
        for (int b = 0; b < KEY_W / 8; b++) begin
            shifted = key >> (8 * b);
            if ((^shifted[7:0]) == 1'b0) begin
                ok = 1'b0;
            end
        end
        return ok;
    endfunction

endpackage

// File: rtl/key_56_to_48.sv
// ----------------------------------------------------------------------------
// key_56_to_48
// DES Permuted Choice 2: selects 48 of the 56 C||D bits to form a round subkey.
// Purely combinational.
// Ports:
//   cd      in  56  C||D register contents (DES bit 1 = MSB)
//   subkey  out 48  PC-2 of cd (DES bit 1 = MSB)
// ----------------------------------------------------------------------------
module key_56_to_48
    import des_pkg::*;
(
    input  logic [CD_W-1:0] cd,
    output logic [SK_W-1:0] subkey
);

    localparam int PC2_TABLE [0:47] = '{
        14, 17, 11, 24,  1,  5,
         3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8,
        16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55,
        30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53,
        46, 42, 50, 36, 29, 32
    };

    always_comb begin
        subkey = '0;
        for (int i = 0; i < SK_W; i++) begin
            subkey[6'(SK_W - 1 - i)] = cd[6'(CD_W - PC2_TABLE[i])];
        end
    end

endmodule

// File: rtl/des_key_schedule_ctrl.sv
// ----------------------------------------------------------------------------
// des_key_schedule_ctrl
// Sequences the DES key schedule for one 64-bit key and streams the sixteen
// 48-bit round subkeys to the round datapath over a valid/ready handshake,
// in encrypt order (K1..K16) or decrypt order (K16..K1).
//
// Optional feature macro: DES_PARITY_CHECK_EN
//   defined   -> odd parity of every key byte is checked at start; a bad key
//                raises key_err and no schedule is started.
//   undefined -> key_err is tied low and parity bits are ignored.
//
// Ports:
//   clk        in   1   rising-edge clock
//   reset      in   1   synchronous, active-high
//   start      in   1   request a new schedule (only honoured in IDLE)
//   decrypt    in   1   sampled with start: 0 = K1..K16, 1 = K16..K1
//   key_in     in  64   DES key, bit 1 = MSB
//   abort      in   1   cancel any schedule and return to IDLE
//   sk_ready   in   1   round datapath accepts the subkey this cycle
//   sk_valid   out  1   subkey valid
//   subkey     out 48   PC-2 of the C||D register
//   round_idx  out  4   position of the presented subkey in delivery order
//   busy       out  1   high in ROUND and DONE
//   done       out  1   one-cycle pulse after the 16th subkey is accepted
//   key_err    out  1   key parity error flag
// ----------------------------------------------------------------------------
module des_key_schedule_ctrl
    import des_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             decrypt,
    input  logic [KEY_W-1:0] key_in,
    input  logic             abort,
    input  logic             sk_ready,
    output logic             sk_valid,
    output logic [SK_W-1:0]  subkey,
    output logic [3:0]       round_idx,
    output logic             busy,
    output logic             done,
    output logic             key_err
);

    state_t              state;
    logic                dec_mode;
    logic [HALF_W-1:0]   c_reg;
    logic [HALF_W-1:0]   d_reg;
    logic [CD_W-1:0]     pc1_key;
    logic                key_ok;
    logic                handshake;

    assign pc1_key   = pc1(key_in);
    assign handshake = sk_valid & sk_ready;

`ifdef DES_PARITY_CHECK_EN
    assign key_ok = key_parity_ok(key_in);

    // The error flag is refreshed on every start attempt seen in IDLE, so a
    // good key clears an earlier failure; abort suppresses the attempt.
    always_ff @(posedge clk) begin
        if (reset) begin
            key_err <= 1'b0;
        end else if (state == ST_IDLE && start && !abort) begin
            key_err <= !key_ok;
        end
    end
`else
    assign key_ok  = 1'b1;
    assign key_err = 1'b0;
`endif

    // The subkey is derived only from the C||D register, so it cannot glitch
    // with the handshake inputs.
    key_56_to_48 u_pc2 (
        .cd     ({c_reg, d_reg}),
        .subkey (subkey)
    );

    // Main sequencer. The C||D register always holds the halves for the
    // subkey being presented; a handshake advances it to the next round.
    // Encrypt preloads the first left rotation so K1 is ready one cycle after
    // start. Decrypt starts from the unrotated PC-1 value, which equals the
    // round-16 state because the total rotation over all rounds is 28.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_IDLE;
            dec_mode  <= 1'b0;
            c_reg     <= '0;
            d_reg     <= '0;
            round_idx <= 4'd0;
            sk_valid  <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else if (abort) begin
            state     <= ST_IDLE;
            round_idx <= 4'd0;
            sk_valid  <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start && key_ok) begin
                        dec_mode  <= decrypt;
                        round_idx <= 4'd0;
                        sk_valid  <= 1'b1;
                        busy      <= 1'b1;
                        state     <= ST_ROUND;
                        if (decrypt) begin
                            c_reg <= pc1_key[CD_W-1:HALF_W];
                            d_reg <= pc1_key[HALF_W-1:0];
                        end else begin
                            c_reg <= rotate_left(pc1_key[CD_W-1:HALF_W], SHIFT_TABLE[0]);
                            d_reg <= rotate_left(pc1_key[HALF_W-1:0], SHIFT_TABLE[0]);
                        end
                    end
                end
                ST_ROUND: begin
                    if (handshake) begin
                        if (round_idx == 4'd15) begin
                            sk_valid <= 1'b0;
                            done     <= 1'b1;
                            state    <= ST_DONE;
                        end else begin
                            round_idx <= round_idx + 4'd1;
                            if (dec_mode) begin
                                c_reg <= rotate_right(c_reg, SHIFT_TABLE[4'd15 - round_idx]);
                                d_reg <= rotate_right(d_reg, SHIFT_TABLE[4'd15 - round_idx]);
                            end else begin
                                c_reg <= rotate_left(c_reg, SHIFT_TABLE[round_idx + 4'd1]);
                                d_reg <= rotate_left(d_reg, SHIFT_TABLE[round_idx + 4'd1]);
                            end
                        end
                    end
                end
                ST_DONE: begin
                    busy      <= 1'b0;
                    round_idx <= 4'd0;
                    state     <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
